fir8_mac_seq: RTL and testbench

FIR8_MAC_SEQ -- requirements
Module: fir8_mac_seq

---
 rtl/fir8_mac_seq.sv | 133 +++++++++++++
 tb/tb_fir8_mac_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir8_mac_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fir8_mac_seq : 8-tap FIR evaluated serially with one signed MAC per clock
// Revision 1.0
// ---------------------------------------------------------------------------
module fir8_mac_seq #(
  parameter int W = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic signed [W-1:0]   A,
  input  logic signed [W-1:0]   B,
  input  logic signed [W-1:0]   C,
  input  logic signed [W-1:0]   D,
  input  logic signed [W-1:0]   E,
  input  logic signed [W-1:0]   F,
  input  logic signed [W-1:0]   G,
  input  logic signed [W-1:0]   H,
  input  logic                  Start,
  input  logic                  CoefWe,
  input  logic [2:0]            CoefAddr,
  input  logic signed [W-1:0]   CoefData,
  output logic                  Busy,
  output logic                  Done,
  output logic signed [2*W+2:0] Y
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MAC  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic signed [2*W+2:0] acc_q, acc_d;
  logic signed [2*W+2:0] y_q, y_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic signed [W-1:0]   snap_q [8];
  logic signed [W-1:0]   snap_d [8];
  logic signed [W-1:0]   coef_q [8];
  logic signed [W-1:0]   coef_d [8];
  logic signed [W-1:0]   tap_in [8];

  logic signed [2*W-1:0] mul_a, mul_b, prod;
  logic signed [2*W+2:0] prod_ext, sum;

  always_comb begin
    tap_in[0] = A;
    tap_in[1] = B;
    tap_in[2] = C;
    tap_in[3] = D;
    tap_in[4] = E;
    tap_in[5] = F;
    tap_in[6] = G;
    tap_in[7] = H;
  end

  // Operands widened first so the product is a full-precision 2W-bit signed value.
  assign mul_a    = {{W{snap_q[idx_q][W-1]}}, snap_q[idx_q]};
  assign mul_b    = {{W{coef_q[idx_q][W-1]}}, coef_q[idx_q]};
  assign prod     = mul_a * mul_b;
  assign prod_ext = {{3{prod[2*W-1]}}, prod};
  assign sum      = acc_q + prod_ext;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    snap_d  = snap_q;
    coef_d  = coef_q;
    case (state_q)
      IDLE: begin
        if (CoefWe) coef_d[CoefAddr] = CoefData;
        if (Start) begin
          snap_d  = tap_in;
          acc_d   = '0;
          idx_d   = 3'd0;
          busy_d  = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = sum;
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          y_d     = sum;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          idx_d   = 3'd0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      acc_q   <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        snap_q[i] <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      snap_q  <= snap_d;
      coef_q  <= coef_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Y    = y_q;

endmodule
`default_nettype wire

// File: tb/tb_fir8_mac_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fir8_mac_seq : randomized self-checking bench against a sum-of-products model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_fir8_mac_seq;
  localparam int W = 16;

  logic                  Clock = 1'b0;
  logic                  Reset;
  logic                  Start;
  logic                  CoefWe;
  logic [2:0]            CoefAddr;
  logic signed [W-1:0]   CoefData;
  logic signed [W-1:0]   tap_v [8];
  logic                  Busy;
  logic                  Done;
  logic signed [2*W+2:0] Y;

  logic signed [W-1:0]   coef_m [8];
  int                    n_cmp = 0;
  int                    n_err = 0;
  int                    done_edge;
  bit                    seq_bad;

  always #5 Clock = ~Clock;

  fir8_mac_seq #(.W(W)) dut (
    .Clock(Clock), .Reset(Reset),
    .A(tap_v[0]), .B(tap_v[1]), .C(tap_v[2]), .D(tap_v[3]),
    .E(tap_v[4]), .F(tap_v[5]), .G(tap_v[6]), .H(tap_v[7]),
    .Start(Start), .CoefWe(CoefWe), .CoefAddr(CoefAddr), .CoefData(CoefData),
    .Busy(Busy), .Done(Done), .Y(Y)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic longint model_y();
    longint s = 0;
    for (int i = 0; i < 8; i++) s += longint'(tap_v[i]) * longint'(coef_m[i]);
    return s;
  endfunction

  task automatic rand_taps();
    for (int i = 0; i < 8; i++) tap_v[i] = W'($urandom);
  endtask

  task automatic write_coef(input logic [2:0] a, input logic signed [W-1:0] d);
    CoefWe = 1'b1; CoefAddr = a; CoefData = d;
    tick();
    CoefWe = 1'b0;
    coef_m[a] = d;
  endtask

  // Starts one evaluation and follows it until Done; records the Done edge
  // offset and whether Busy/Done/Y ever misbehaved on the way.
  task automatic run_eval();
    logic signed [2*W+2:0] y_prev;
    y_prev = Y;
    Start = 1'b1;
    tick();
    Start  = 1'b0;
    CoefWe = 1'b0;
    seq_bad   = 1'b0;
    done_edge = -1;
    if (Busy !== 1'b1 || Done !== 1'b0) seq_bad = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (Done === 1'b1) begin
        done_edge = n;
        if (Busy !== 1'b0) seq_bad = 1'b1;
        break;
      end
      if (n < 8 && Busy !== 1'b1) seq_bad = 1'b1;
      if (Y !== y_prev) seq_bad = 1'b1;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      Start = 1'($urandom); CoefWe = 1'($urandom);
      CoefAddr = 3'($urandom); CoefData = W'($urandom);
      rand_taps();
      tick();
    end
    n_cmp++; if (Y !== '0) begin n_err++; $display("FAIL reset_y: got %0d expected 0", Y); end
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    n_cmp++; if (Done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", Done); end
    Reset = 1'b1; Start = 1'b0; CoefWe = 1'b0;
    for (int i = 0; i < 8; i++) coef_m[i] = '0;
    rand_taps();
    run_eval();
    n_cmp++; if (done_edge != 8) begin n_err++; $display("FAIL reset_eval_latency: got %0d expected 8", done_edge); end
    n_cmp++; if (Y !== '0) begin n_err++; $display("FAIL reset_eval_y: got %0d expected 0", Y); end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 8; i++) begin
      write_coef(3'(i), 16'sd1);
      tap_v[i] = W'(i + 1);
    end
    run_eval();
    n_cmp++; if (done_edge != 8) begin n_err++; $display("FAIL basic_latency: got %0d expected 8", done_edge); end
    n_cmp++; if (seq_bad) begin n_err++; $display("FAIL basic_busy_seq: got 1 expected 0"); end
    n_cmp++; if (Y !== 35'sd36) begin n_err++; $display("FAIL basic_y: got %0d expected 36", Y); end
  endtask

  task automatic test_signed();
    logic signed [2*W+2:0] e;
    for (int i = 0; i < 8; i++) write_coef(3'(i), 16'sd0);
    write_coef(3'd0, 16'shFFFF);
    rand_taps();
    tap_v[0] = 16'sh8000;
    run_eval();
    e = 35'sd32768;
    n_cmp++; if (Y !== e) begin n_err++; $display("FAIL signed_pos: got %0d expected %0d", Y, e); end
    write_coef(3'd0, 16'sd2);
    run_eval();
    e = -35'sd65536;
    n_cmp++; if (Y !== e) begin n_err++; $display("FAIL signed_neg: got %0d expected %0d", Y, e); end
  endtask

  task automatic test_extreme();
    logic signed [2*W+2:0] e;
    for (int i = 0; i < 8; i++) begin
      write_coef(3'(i), 16'sh8000);
      tap_v[i] = 16'sh8000;
    end
    run_eval();
    e = 35'sh2_0000_0000;
    n_cmp++; if (Y !== e) begin n_err++; $display("FAIL extreme_y: got %0h expected %0h", Y, e); end
  endtask

  task automatic test_random();
    logic signed [2*W+2:0] e;
    for (int it = 0; it < 16; it++) begin
      for (int j = 0; j < int'($urandom_range(0, 3)); j++)
        write_coef(3'($urandom), W'($urandom));
      rand_taps();
      if ($urandom_range(0, 1) == 1) begin
        CoefWe = 1'b1; CoefAddr = 3'($urandom); CoefData = W'($urandom);
        coef_m[CoefAddr] = CoefData;
      end
      e = 35'(model_y());
      run_eval();
      n_cmp++; if (Y !== e || done_edge != 8 || seq_bad) begin
        n_err++; $display("FAIL random_eval[%0d]: got y=%0d edge=%0d bad=%0b expected y=%0d edge=8 bad=0",
                          it, Y, done_edge, seq_bad, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic signed [2*W+2:0] e;
    rand_taps();
    e = 35'(model_y());
    run_eval();
    n_cmp++; if (Y !== e) begin n_err++; $display("FAIL b2b_first: got %0d expected %0d", Y, e); end
    // Start and a coefficient write land in the very cycle Done is high.
    rand_taps();
    CoefWe = 1'b1; CoefAddr = 3'($urandom); CoefData = W'($urandom);
    coef_m[CoefAddr] = CoefData;
    e = 35'(model_y());
    run_eval();
    n_cmp++; if (done_edge != 8) begin n_err++; $display("FAIL b2b_latency: got %0d expected 8", done_edge); end
    n_cmp++; if (Y !== e) begin n_err++; $display("FAIL b2b_second: got %0d expected %0d", Y, e); end
  endtask

  task automatic test_ignored();
    logic signed [2*W+2:0] e;
    int done_cnt, first;
    for (int i = 0; i < 8; i++) begin
      write_coef(3'(i), 16'sd1);
      tap_v[i] = W'(i + 1);
    end
    Start = 1'b1;
    tick();
    Start = 1'b0;
    done_cnt = 0; first = -1;
    for (int n = 1; n <= 20; n++) begin
      if (n == 3) begin
        Start = 1'b1;
        for (int i = 0; i < 8; i++) tap_v[i] = 16'sh7FFF;
      end
      if (n == 4) begin
        Start = 1'b0; CoefWe = 1'b1;
        CoefAddr = 3'($urandom); CoefData = 16'sh1234;
      end
      if (n == 5) CoefWe = 1'b0;
      tick();
      if (Done === 1'b1) begin
        done_cnt++;
        if (first < 0) first = n;
      end
    end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL ignored_done_count: got %0d expected 1", done_cnt); end
    n_cmp++; if (first != 8) begin n_err++; $display("FAIL ignored_done_edge: got %0d expected 8", first); end
    n_cmp++; if (Y !== 35'sd36) begin n_err++; $display("FAIL ignored_y: got %0d expected 36", Y); end
    rand_taps();
    e = 35'(model_y());
    run_eval();
    n_cmp++; if (Y !== e) begin n_err++; $display("FAIL ignored_coef_kept: got %0d expected %0d", Y, e); end
  endtask

  task automatic test_abort();
    int done_cnt;
    for (int i = 0; i < 8; i++) write_coef(3'(i), W'($urandom_range(1, 1000)));
    rand_taps();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick(); tick(); tick();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", Busy); end
    n_cmp++; if (Y !== '0) begin n_err++; $display("FAIL abort_y: got %0d expected 0", Y); end
    done_cnt = (Done === 1'b1) ? 1 : 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (Done === 1'b1) done_cnt++;
    end
    n_cmp++; if (done_cnt != 0) begin n_err++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt); end
    for (int i = 0; i < 8; i++) coef_m[i] = '0;
    rand_taps();
    run_eval();
    n_cmp++; if (Y !== '0 || done_edge != 8) begin
      n_err++; $display("FAIL abort_coef_cleared: got y=%0d edge=%0d expected y=0 edge=8", Y, done_edge);
    end
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; CoefWe = 1'b0; CoefAddr = '0; CoefData = '0;
    for (int i = 0; i < 8; i++) begin
      tap_v[i] = '0;
      coef_m[i] = '0;
    end
    test_reset();
    test_basic();
    test_signed();
    test_extreme();
    test_random();
    test_back_to_back();
    test_ignored();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
